// File: rtl/ciphertext_pkg.sv
// ciphertext_pkg
//   Shared constants and helpers for the ciphertext rescale slice.
//   clog2_const  : constant-foldable ceil(log2(value)), used for shift and
//                  counter widths.
//   Q_LOG2, PROD_WIDTH, IDX_WIDTH, COEF_COUNT : values for the default
//                  configuration (q=1024, t width 6, coeff width 21, D=3).
//                  Modules re-derive their own copies from their parameters.
package ciphertext_pkg;

  function automatic int unsigned clog2_const(input int unsigned value);
    int unsigned result;
    longint unsigned span;
    result = 0;
    span   = 1;
    while (span < longint'(value)) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  localparam int unsigned Q_LOG2     = clog2_const(1024);
  localparam int unsigned PROD_WIDTH = 21 + 6 + 1;
  localparam int unsigned IDX_WIDTH  = 3 + 1;
  localparam int unsigned COEF_COUNT = 2 * 3 + 1;

endpackage

// File: rtl/rescale_fifo.sv
// rescale_fifo
//   First-word fall-through FIFO holding rescaled coefficients.
//   Push and pop in the same cycle are accepted at any occupancy; a pop
//   on an empty FIFO is ignored, a push on a full FIFO only lands when a
//   pop frees the slot in the same cycle.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data this cycle
//   pop        : retire the head entry this cycle
//   push_data  : entry to write
//   pop_data   : head entry (valid while !empty)
//   count      : current occupancy, 0..DEPTH
//   full/empty : occupancy flags
module rescale_fifo
  import ciphertext_pkg::*;
#(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = clog2_const(DEPTH + 1),
  localparam int unsigned PTR_W = clog2_const(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_next;
  logic [PTR_W-1:0] rd_next;
  logic             push_en;
  logic             pop_en;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    pop_en  = pop && !empty;
    push_en = push && (!full || pop_en);
    // Explicit wrap keeps non-power-of-two depths correct.
    wr_next = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    rd_next = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_next;
      end
      if (pop_en) begin
        rd_ptr <= rd_next;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ciphertext_rescale.sv
// ciphertext_rescale
//   Rescales product coefficients from homomorphic_multiply: each signed
//   coefficient is multiplied by t, divided by q (q a power of two) and
//   reduced into [0, q). Two registered stages feed a credit-limited FWFT
//   FIFO so downstream backpressure never stalls the pipeline.
//   Build option CIPHERTEXT_RESCALE_ROUND_EN: when defined, q/2 is added
//   before the shift (round-half-up); otherwise the shift floors.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : in_entry holds a coefficient
//   in_entry   : signed product coefficient
//   in_ready   : a coefficient is accepted this cycle if in_valid
//   out_valid  : out_entry/out_index/out_last hold the FIFO head
//   out_entry  : rescaled coefficient in [0, q)
//   out_index  : coefficient index 0..2*DIMENSION
//   out_last   : head is the final coefficient of a product
//   out_ready  : downstream takes the head this cycle
module ciphertext_rescale
  import ciphertext_pkg::*;
#(
  parameter int unsigned PLAINTEXT_MODULUS  = 64,
  parameter int unsigned PLAINTEXT_WIDTH    = 6,
  parameter int unsigned CIPHERTEXT_MODULUS = 1024,
  parameter int unsigned CIPHERTEXT_WIDTH   = 21,
  parameter int unsigned DIMENSION          = 3,
  parameter int unsigned BIG_N              = 30,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic signed [CIPHERTEXT_WIDTH-1:0] in_entry,
  output logic                               in_ready,
  output logic                               out_valid,
  output logic        [CIPHERTEXT_WIDTH-1:0] out_entry,
  output logic        [DIMENSION:0]          out_index,
  output logic                               out_last,
  input  logic                               out_ready
);

  localparam int unsigned CW       = CIPHERTEXT_WIDTH;
  localparam int unsigned QSH      = clog2_const(CIPHERTEXT_MODULUS);
  localparam int unsigned PW       = CIPHERTEXT_WIDTH + PLAINTEXT_WIDTH + 1;
  localparam int unsigned IW       = DIMENSION + 1;
  localparam int unsigned LAST_IDX = 2 * DIMENSION;
  localparam int unsigned DW       = CW + IW + 1;
  localparam int unsigned CNT_W    = clog2_const(FIFO_DEPTH + 1);

  localparam logic signed [PW-1:0] T_S        = PW'(PLAINTEXT_MODULUS);
  localparam logic        [CW-1:0] ENTRY_MASK = CW'(CIPHERTEXT_MODULUS - 1);
`ifdef CIPHERTEXT_RESCALE_ROUND_EN
  localparam logic signed [PW-1:0] ADDEND     = PW'(CIPHERTEXT_MODULUS / 2);
`else
  localparam logic signed [PW-1:0] ADDEND     = '0;
`endif

  if ((FIFO_DEPTH < 3) || (CIPHERTEXT_MODULUS != (32'd1 << QSH)) || (BIG_N == 0))
  begin : g_bad_config
    $error("ciphertext_rescale: FIFO_DEPTH must be >= 3, CIPHERTEXT_MODULUS a power of two, BIG_N non-zero");
  end

  logic                 accept;
  logic                 s1_valid;
  logic signed [PW-1:0] s1_prod;
  logic        [IW-1:0] s1_idx;
  logic        [IW-1:0] idx_cnt;
  logic                 s2_valid;
  logic        [CW-1:0] s2_entry;
  logic        [IW-1:0] s2_idx;
  logic                 s2_last;
  logic                 pop;
  logic       [DW-1:0]  head;
  logic    [CNT_W-1:0]  fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Credit counts FIFO entries plus entries still in the two stages, so
  // every accepted coefficient already owns a FIFO slot when it arrives.
  always_comb begin
    in_ready = !fifo_full &&
               ((32'(fifo_count) + 32'(s1_valid) + 32'(s2_valid)) < FIFO_DEPTH);
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_idx   <= '0;
      idx_cnt  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod <= PW'(in_entry) * T_S;
        s1_idx  <= idx_cnt;
        idx_cnt <= (idx_cnt == IW'(LAST_IDX)) ? '0 : idx_cnt + 1'b1;
      end
    end
  end

  // Masking the low bits of the arithmetic shift already yields the
  // non-negative residue mod q, so no sign correction is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_entry <= '0;
      s2_idx   <= '0;
      s2_last  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_entry <= CW'((s1_prod + ADDEND) >>> QSH) & ENTRY_MASK;
      s2_idx   <= s1_idx;
      s2_last  <= (s1_idx == IW'(LAST_IDX));
    end
  end

  rescale_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_valid),
    .pop       (pop),
    .push_data ({s2_entry, s2_idx, s2_last}),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    out_valid = !fifo_empty;
    pop       = out_valid && out_ready;
    if (fifo_empty) begin
      {out_entry, out_index, out_last} = '0;
    end else begin
      {out_entry, out_index, out_last} = head;
    end
  end

endmodule

// File: tb/tb_ciphertext_rescale.sv
module tb_ciphertext_rescale;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [20:0] in_entry;
  logic               in_ready;
  logic               out_valid;
  logic        [20:0] out_entry;
  logic        [3:0]  out_index;
  logic               out_last;
  logic               out_ready;

  int total = 0;
  int bad   = 0;
  int accepted;
  int n;

  int single_in  [5] = '{8, 16, 1000, -8, 20000};
  int stream_in  [7] = '{8, 16, 24, 32, 24, 16, 8};
`ifdef CIPHERTEXT_RESCALE_ROUND_EN
  int single_exp [5] = '{1, 1, 63, 0, 226};
  int stream_exp [7] = '{1, 1, 2, 2, 2, 1, 1};
`else
  int single_exp [5] = '{0, 1, 62, 1023, 226};
  int stream_exp [7] = '{0, 1, 1, 2, 1, 1, 0};
`endif

  always #5 clk = ~clk;

  ciphertext_rescale #(
    .PLAINTEXT_MODULUS  (64),
    .PLAINTEXT_WIDTH    (6),
    .CIPHERTEXT_MODULUS (1024),
    .CIPHERTEXT_WIDTH   (21),
    .DIMENSION          (3),
    .BIG_N              (30),
    .FIFO_DEPTH         (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_entry  (in_entry),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_entry (out_entry),
    .out_index (out_index),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_single(input int value, input int exp, input int idx, input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    in_entry = 21'(value);
    step();
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 32'(out_valid), 0);
    step();
    check({tag, "_lat2_valid"}, 32'(out_valid), 0);
    step();
    check({tag, "_lat3_valid"}, 32'(out_valid), 1);
    check({tag, "_entry"}, 32'(out_entry), 32'(exp));
    check({tag, "_index"}, 32'(out_index), 32'(idx));
    check({tag, "_last"}, 32'(out_last), 32'(idx == 6));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_entry  = 21'sd8;
    out_ready = 1'b1;

    // Reset held with in_valid high
    for (int c = 0; c < 5; c++) begin
      step();
      check("rst_out_valid", 32'(out_valid), 0);
    end
    check("rst_out_entry", 32'(out_entry), 0);
    check("rst_out_index", 32'(out_index), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
    rst      = 1'b0;
    step();
    check("rel_in_ready", 32'(in_ready), 1);
    step();
    step();
    check("rel_nothing_accepted", 32'(out_valid), 0);

    // Single coefficients
    for (int i = 0; i < 5; i++) begin
      send_single(single_in[i], single_exp[i], i, "single");
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_out_valid", 32'(out_valid), 0);

    // Full product stream, one per cycle
    for (int i = 0; i < 9; i++) begin
      if (i < 7) begin
        check("stream_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_entry = 21'(stream_in[i]);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 2) begin
        check("stream_valid", 32'(out_valid), 1);
        check("stream_entry", 32'(out_entry), 32'(stream_exp[i-2]));
        check("stream_index", 32'(out_index), 32'(i - 2));
        check("stream_last", 32'(out_last), 32'((i - 2) == 6));
      end
    end
    step();
    send_single(8, stream_exp[0], 0, "restream");

    // Backpressure
    rst = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 10; c++) begin
      check("bp_in_ready", 32'(in_ready), 32'(accepted < 4));
      in_valid = 1'b1;
      in_entry = 21'(8 * (c + 1));
      if (in_ready) accepted++;
      step();
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(accepted), 4);
    check("bp_in_ready_low", 32'(in_ready), 0);
    check("bp_out_valid", 32'(out_valid), 1);
    check("bp_head_entry", 32'(out_entry), 32'(stream_exp[0]));
    check("bp_head_index", 32'(out_index), 0);
    step();
    step();
    check("bp_hold_entry", 32'(out_entry), 32'(stream_exp[0]));
    check("bp_hold_index", 32'(out_index), 0);
    check("bp_hold_ready", 32'(in_ready), 0);

    out_ready = 1'b1;
    check("bp_pre_pop_ready", 32'(in_ready), 0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (n < 4) begin
          check("bp_drain_entry", 32'(out_entry), 32'(stream_exp[n]));
          check("bp_drain_index", 32'(out_index), 32'(n));
        end else begin
          check("bp_drain_extra", 32'(out_valid), 0);
        end
        n++;
      end
      step();
      if (c == 0) check("bp_ready_return", 32'(in_ready), 1);
    end
    check("bp_drained_count", 32'(n), 4);
    check("bp_drained_empty", 32'(out_valid), 0);

    // Mid-stream reset
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_entry = 21'(single_in[k]);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("mr_fifo_nonempty", 32'(out_valid), 1);
    rst = 1'b1;
    step();
    check("mr_out_valid", 32'(out_valid), 0);
    check("mr_in_ready", 32'(in_ready), 1);
    rst       = 1'b0;
    out_ready = 1'b1;
    send_single(1000, single_exp[2], 0, "mr_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
